// File: rtl/float_struct_pkg.sv
// Shared float types for the FPU staging logic: the single-precision
// float struct, its zero constant, and the serializer state encoding.
package float_struct;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } float_point_num;

  localparam float_point_num FLOAT_ZERO = '{sign: 1'b0, exp: 8'd0, mant: 23'd0};

  typedef enum logic {IDLE, SHIFT} ser_state_t;

endpackage

// File: rtl/float_struct_serializer.sv
// Loads a STAGES-deep float vector in one handshake and drains it one element
// per beat, element 0 first. Define FP_SER_LAST_EN to add the out_last port.
module float_struct_serializer
  import float_struct::*;
#(
  parameter int STAGES = 6,
  parameter int IDX_W  = $clog2(STAGES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  float_point_num [0:STAGES-1] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output float_point_num              out_data,
  output logic [IDX_W-1:0]            out_idx
`ifdef FP_SER_LAST_EN
  ,
  output logic                        out_last
`endif
);

  ser_state_t                  state, state_next;
  float_point_num [0:STAGES-1] data_buf;
  logic [IDX_W-1:0]            cnt;
  logic                        at_last, load, out_hs;

  assign at_last   = (cnt == IDX_W'(STAGES - 1));
  // in_ready looks at out_ready so a new vector can load on the final beat.
  assign in_ready  = en && !rst &&
                     ((state == IDLE) || ((state == SHIFT) && at_last && out_ready));
  assign out_valid = en && (state == SHIFT);
  assign out_data  = data_buf[0];
  assign out_idx   = cnt;
  assign load      = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

`ifdef FP_SER_LAST_EN
  assign out_last  = out_valid && at_last;
`endif

  always_comb begin
    state_next = state;
    if (load)
      state_next = SHIFT;
    else if (out_hs && at_last)
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_buf <= {STAGES{FLOAT_ZERO}};
    end else begin
      state <= state_next;
      // A load on the final beat wins over the zero shift-in.
      if (load) begin
        data_buf <= in_data;
        cnt      <= '0;
      end else if (out_hs) begin
        for (int i = 0; i < STAGES - 1; i++)
          data_buf[i] <= data_buf[i+1];
        data_buf[STAGES-1] <= FLOAT_ZERO;
        cnt <= at_last ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_float_struct_serializer.sv
// Directed cycle table for float_struct_serializer (STAGES=6), plus
// back-to-back and mid-vector reset sequences.
module tb_float_struct_serializer;
  import float_struct::*;

  localparam int STAGES = 6;
  localparam int IDX_W  = 3;

  logic                        clk = 1'b0;
  logic                        rst, en, in_valid, in_ready;
  float_point_num [0:STAGES-1] in_data;
  logic                        out_valid, out_ready;
  float_point_num              out_data;
  logic [IDX_W-1:0]            out_idx;
`ifdef FP_SER_LAST_EN
  logic                        out_last;
`endif

  float_struct_serializer #(.STAGES(STAGES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
`ifdef FP_SER_LAST_EN
    , .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, iv, ordy;
    logic [22:0] base;
    logic        ir, ov;
    logic [2:0]  idx;
    logic [31:0] data;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int row    = 0;

  function automatic logic [31:0] fp(input int m);
    logic [22:0] mm;
    mm = 23'(m);
    return {1'b0, 8'h7F, mm};
  endfunction

  function automatic vec_t v(input logic r, e, iv, ordy, input int base,
                             input logic ir, ov, input int idx, input logic [31:0] data);
    vec_t t;
    t.rst = r; t.en = e; t.iv = iv; t.ordy = ordy; t.base = 23'(base);
    t.ir = ir; t.ov = ov; t.idx = 3'(idx); t.data = data;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, check before the rising edge.
  task automatic step(input vec_t t);
    @(negedge clk);
    rst = t.rst; en = t.en; in_valid = t.iv; out_ready = t.ordy;
    for (int i = 0; i < STAGES; i++) in_data[i] = float_point_num'(fp(int'(t.base) + i));
    #1;
    chk("in_ready",  32'(in_ready),  32'(t.ir));
    chk("out_valid", 32'(out_valid), 32'(t.ov));
    chk("out_idx",   32'(out_idx),   32'(t.idx));
    chk("out_data",  32'(out_data),  t.data);
`ifdef FP_SER_LAST_EN
    chk("out_last",  32'(out_last),  32'(t.ov && t.idx == 3'd5));
`endif
    row++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // reset held 3 cycles with in_valid high, then release
    for (int k = 0; k < 3; k++) tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0));
    // plain drain of mant 0..5
    tbl.push_back(v(0, 1, 1, 1, 0, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(v(0, 1, 0, 1, 0, k == 5, 1, k, fp(k)));
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, 0));
    // backpressure at idx 2 for 3 cycles
    tbl.push_back(v(0, 1, 1, 1, 'h20, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 'h20, 0, 1, 0, fp('h20)));
    tbl.push_back(v(0, 1, 0, 1, 'h20, 0, 1, 1, fp('h21)));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 0, 0, 'h20, 0, 1, 2, fp('h22)));
    for (int k = 2; k < 6; k++) tbl.push_back(v(0, 1, 0, 1, 'h20, k == 5, 1, k, fp('h20 + k)));
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, 0));
    // en stall for 4 cycles at idx 3
    tbl.push_back(v(0, 1, 1, 1, 'h40, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 0, 1, 'h40, 0, 1, k, fp('h40 + k)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 0, 1, 1, 'h40, 0, 0, 3, fp('h43)));
    for (int k = 3; k < 6; k++) tbl.push_back(v(0, 1, 0, 1, 'h40, k == 5, 1, k, fp('h40 + k)));
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, 0));
    // en low in IDLE blocks a load
    tbl.push_back(v(0, 0, 1, 1, 'h60, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 'h60, 1, 0, 0, 0));

    foreach (tbl[k]) step(tbl[k]);

    // back-to-back: A (mant 0..5) then B (mant 10..15), B loads on A's last beat
    step(v(0, 1, 1, 1, 0, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++) step(v(0, 1, 1, 1, 10, k == 5, 1, k, fp(k)));
    for (int k = 0; k < 6; k++) step(v(0, 1, 0, 1, 10, k == 5, 1, k, fp(10 + k)));
    step(v(0, 1, 0, 1, 0, 1, 0, 0, 0));

    // mid-vector reset at idx 2, then a fresh vector starts at idx 0
    step(v(0, 1, 1, 1, 'h30, 1, 0, 0, 0));
    step(v(0, 1, 0, 1, 'h30, 0, 1, 0, fp('h30)));
    step(v(0, 1, 0, 1, 'h30, 0, 1, 1, fp('h31)));
    step(v(1, 1, 0, 0, 'h30, 0, 1, 2, fp('h32)));
    step(v(0, 1, 1, 0, 'h50, 1, 0, 0, 0));
    step(v(0, 1, 0, 1, 'h50, 0, 1, 0, fp('h50)));
    step(v(0, 1, 0, 1, 'h50, 0, 1, 1, fp('h51)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/float_struct_serializer.md
# float_struct_serializer

Parallel-in, serial-out companion to the FPU's staged float shift register. It accepts a whole vector of `STAGES` `float_point_num` values in one handshake and emits them one per accepted beat, element 0 first. The FPU pipeline uses it to drain a captured stage snapshot into a single-lane float consumer. All transfers use valid/ready handshakes, and a global `en` stalls the block.

## Interface
- `STAGES`, 6: vector length; must be ≥ 2.
- `IDX_W`, `$clog2(STAGES)`: width of the element index.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: global enable; when low, all state is frozen and no handshake completes.
- `in_valid`  in  1: `in_data` holds a vector to load.
- `in_ready`  out  1: the block can accept a vector this cycle.
- `in_data`  in  `float_point_num [0:STAGES-1]`: vector to load, sampled only on an accepting edge.
- `out_valid`  out  1: `out_data` holds a valid element.
- `out_ready`  in  1: the consumer takes `out_data` this cycle.
- `out_data`  out  `float_point_num`: current element.
- `out_idx`  out  `IDX_W`: index of `out_data` within its vector.
- `out_last`  out  1: present only with `FP_SER_LAST_EN`; marks element `STAGES-1`.

## Operation
- Two states:
  - IDLE: buffer empty.
  - SHIFT: buffer holds the unsent elements.
- Load handshake: `en && in_valid && in_ready` at an edge.
- Output handshake: `en && out_valid && out_ready` at an edge.
- Outputs:
  - `in_ready = en && !rst && (IDLE || (SHIFT && cnt==STAGES-1 && out_ready))`.
  - `out_valid = en && SHIFT`.
  - `out_data = buf[0]`.
  - `out_idx = cnt`.
- IDLE with load: `buf <= in_data`, `cnt <= 0`, state moves to SHIFT.
- SHIFT with output handshake:
  - `buf[i] <= buf[i+1]` for i < STAGES-1.
  - `buf[STAGES-1] <= '{sign:0, exp:0, mant:0}`.
  - `cnt <= cnt+1`.
- SHIFT, output handshake with `cnt==STAGES-1`:
  - With no load, state moves to IDLE and `cnt <= 0`. The buffer is now all zero, so `out_data` reads zero in IDLE.
  - With a simultaneous load, the new vector is loaded, `cnt <= 0`, and the state stays SHIFT. The load takes priority over the zero shift-in.
- Backpressure: SHIFT with `out_ready=0` holds `buf`, `cnt`, `out_data` and `out_idx` stable.
- `en=0`: `in_ready` and `out_valid` are forced low and all registers hold. Nothing is lost or duplicated across a stall.
- Reset (takes effect at any time, including mid-vector): the partially sent vector is discarded.
  - State becomes IDLE, `cnt=0`, all `buf` entries zero.
  - `out_valid=0`, `out_data` zero, `out_idx=0`, `out_last=0`.
  - `in_ready=0` while `rst` is high, and 1 in the first cycle after `rst` falls (given `en=1`).
- `in_data` content is not checked; NaN, Inf and denormal values pass bit-exact.

## Timing
- Load accepted at edge N: `out_valid=1` with element 0 during cycle N+1.
- With `out_ready` held high: elements 0..STAGES-1 appear on consecutive cycles N+1..N+STAGES.
- With `in_valid` also held high: back-to-back vectors give 100% output duty cycle, with no bubble between vectors.
- Combinational paths:
  - `in_ready` depends on `out_ready` (for back-to-back).
  - `out_valid` depends only on state and `en`.
  - No other input-to-output paths.

## Configuration
- `FP_SER_LAST_EN` defined:
  - `out_last` port exists.
  - `out_last = out_valid && cnt==STAGES-1`.
- `FP_SER_LAST_EN` undefined:
  - Port absent; no related logic.
  - `out_idx` alone identifies vector boundaries.

## Structure
- `float_point_num` (sign 1, exp 8, mant 23) and a `FLOAT_ZERO` constant live in the shared `float_struct` package.
- The state enum `ser_state_t` (IDLE, SHIFT) is added to the same package.
- No sub-module; buffer, counter and FSM sit in one always_ff plus combinational handshake logic.

## Test plan
- Reset, then hold `rst=1` for 3 cycles with `in_valid=1`:
  - While `rst=1`: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_idx=0`.
  - After release: `in_ready=1`.
- STAGES=6, load element i = `{0, 8'h7F, i}`, `out_ready=1`:
  - Cycles N+1..N+6 show mant 0..5 with idx 0..5.
  - `out_last` is high only at idx 5.
  - Cycle N+7: IDLE, `out_valid=0`.
- Backpressure: drop `out_ready` for 3 cycles at idx 2 → idx 2 and its data stay stable, and the remaining elements follow without loss.
- Stall: drop `en` for 4 cycles at idx 3 with `out_ready=1` → `out_valid=0`, `in_ready=0`, and output resumes at idx 3.
- Back-to-back: hold `in_valid` with vector A (mant 0..5) then vector B (mant 10..15), `out_ready=1` → 12 consecutive valid beats and B loads on A's idx-5 edge.
- Mid-vector reset: assert `rst` at idx 2 → next cycle IDLE with zero outputs, and a new vector then starts at idx 0.
